// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, syncs, visible strobe and line/frame pulses.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // pix_en is a plain advance enable, not a handshake: when low, every
  // register (coordinates, syncs, pulses, counter) holds its value.
  logic       run;
  logic [9:0] nx;
  logic [9:0] ny;

  // The first enabled edge after reset holds (0,0) so pixel (0,0) is emitted.
  always_comb begin
    nx = DrawX;
    ny = DrawY;
    if (!run) begin
      nx = '0;
      ny = '0;
    end else if (DrawX == H_LAST) begin
      nx = '0;
      ny = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end else begin
      nx = DrawX + 10'd1;
    end
  end

  // Decodes come from next-state coordinates so they line up with DrawX/DrawY.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      run         <= 1'b1;
      DrawX       <= nx;
      DrawY       <= ny;
      hs          <= !((nx >= HS_START) && (nx < HS_END));
      vs          <= !((ny >= VS_START) && (ny < VS_END));
      blank       <= (nx < H_VIS) && (ny < V_VIS);
      line_start  <= (nx == 10'd0);
      frame_start <= (nx == 10'd0) && (ny == 10'd0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (pix_en && (nx == 10'd0) && (ny == 10'd0)) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level behaviour, and a
// small-timing instance for whole-frame, frame-counter and mid-frame reset behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Small timing: H 8/2/3/2 (total 15, hs low 10..12), V 4/1/2/1 (total 8, vs low 5..6).
  localparam int B_HT    = 15;
  localparam int B_VT    = 8;
  localparam int B_FRAME = B_HT * B_VT;
  localparam int SCAN    = 257 * B_FRAME;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic reset_a_n, pix_en_a, reset_b_n, pix_en_b;
  logic [9:0] ax, ay, bx, by;
  logic ahs, avs, ablank, als, afs;
  logic bhs, bvs, bblank, bls, bfs;
  logic [7:0] afc, bfc;

  int checks = 0;
  int errors = 0;

  vga_timing_gen u_dut (
    .vga_clk(vga_clk), .reset_n(reset_a_n), .pix_en(pix_en_a),
    .DrawX(ax), .DrawY(ay), .hs(ahs), .vs(avs), .blank(ablank),
    .line_start(als), .frame_start(afs), .frame_cnt(afc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(reset_b_n), .pix_en(pix_en_b),
    .DrawX(bx), .DrawY(by), .hs(bhs), .vs(bvs), .blank(bblank),
    .line_start(bls), .frame_start(bfs), .frame_cnt(bfc)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [9:0] x, input logic [9:0] y,
                                     input logic h, input logic v, input logic b,
                                     input logic l, input logic f, input logic [7:0] fc);
    return {31'b0, x, y, h, v, b, l, f, fc};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int guard;
    int vs_low;
    int fs_seen;
    int last_fs;
    int fs_period;
    logic [9:0] ex, ey;
    logic [7:0] efc;

    reset_a_n = 1'b0; pix_en_a = 1'b1;
    reset_b_n = 1'b0; pix_en_b = 1'b1;
    run(3);

    // Reset values hold even with pix_en high and edges arriving
    check("a_reset", mk(ax, ay, ahs, avs, ablank, als, afs, afc), mk(10'd0, 10'd0, 1, 1, 0, 0, 0, 8'd0));
    check("b_reset", mk(bx, by, bhs, bvs, bblank, bls, bfs, bfc), mk(10'd0, 10'd0, 1, 1, 0, 0, 0, 8'd0));

    // ---- default instance: line-level behaviour ----
    reset_a_n = 1'b1;
    tick();
    check("a_edge1", mk(ax, ay, ahs, avs, ablank, als, afs, afc),
          mk(10'd0, 10'd0, 1, 1, 1, 1, 1, FC_EN ? 8'd1 : 8'd0));
    tick();
    check("a_edge2", mk(ax, ay, ahs, avs, ablank, als, afs, 8'd0), mk(10'd1, 10'd0, 1, 1, 1, 0, 0, 8'd0));
    run(638);
    check("a_x639_visible", {ax, ablank}, {10'd639, 1'b1});
    tick();
    check("a_x640_blank", {ax, ablank, ahs}, {10'd640, 1'b0, 1'b1});
    run(15);
    check("a_x655_hs_high", {ax, ahs}, {10'd655, 1'b1});

    pix_en_a = 1'b0;
    run(50);
    check("a_freeze_655", mk(ax, ay, ahs, avs, ablank, als, afs, afc),
          mk(10'd655, 10'd0, 1, 1, 0, 0, 0, FC_EN ? 8'd1 : 8'd0));
    pix_en_a = 1'b1;
    tick();
    check("a_x656_hs_low", {ax, ahs}, {10'd656, 1'b0});

    cnt = 0;
    guard = 0;
    while (ahs === 1'b0 && guard < 200) begin
      cnt++;
      tick();
      guard++;
    end
    check("a_hs_width", 64'(cnt), 64'd96);
    check("a_hs_end_x", {ay, ax}, {10'd0, 10'd752});
    run(47);
    check("a_x799", {ax, ay, als}, {10'd799, 10'd0, 1'b0});
    tick();
    check("a_line_wrap", mk(ax, ay, ahs, avs, ablank, als, afs, 8'd0), mk(10'd0, 10'd1, 1, 1, 1, 1, 0, 8'd0));

    // A pulse high when pix_en drops stays high until the next enabled edge
    pix_en_a = 1'b0;
    run(5);
    check("a_pulse_frozen", {ax, ay, als}, {10'd0, 10'd1, 1'b1});
    pix_en_a = 1'b1;
    tick();
    check("a_pulse_release", {ax, als}, {10'd1, 1'b0});

    // ---- small instance: full-frame scan over 257 frames ----
    reset_b_n = 1'b1;
    vs_low = 0;
    fs_seen = 0;
    last_fs = -1;
    fs_period = 0;
    for (int n = 0; n < SCAN; n++) begin
      tick();
      ex  = 10'(n % B_HT);
      ey  = 10'((n / B_HT) % B_VT);
      efc = FC_EN ? 8'((n / B_FRAME) + 1) : 8'd0;
      check("b_scan", mk(bx, by, bhs, bvs, bblank, bls, bfs, bfc),
            mk(ex, ey, !(ex >= 10 && ex < 13), !(ey >= 5 && ey < 7),
               (ex < 8) && (ey < 4), ex == 0, (ex == 0) && (ey == 0), efc));
      if (n < 3 * B_FRAME) begin
        if (bvs === 1'b0) vs_low++;
        if (bfs === 1'b1) begin
          if (last_fs >= 0) fs_period = n - last_fs;
          last_fs = n;
          fs_seen++;
        end
      end
      if (n == 0)             check("b_fc_frame1", 64'(bfc), FC_EN ? 64'd1 : 64'd0);
      if (n == 3 * B_FRAME - 1) check("b_fc_frame3", 64'(bfc), FC_EN ? 64'd3 : 64'd0);
      if (n == 254 * B_FRAME) check("b_fc_frame255", 64'(bfc), FC_EN ? 64'd255 : 64'd0);
      if (n == 255 * B_FRAME) check("b_fc_wrap", 64'(bfc), 64'd0);
    end
    check("b_vs_low_3frames", 64'(vs_low), 64'd90);
    check("b_fs_count", 64'(fs_seen), 64'd3);
    check("b_fs_period", 64'(fs_period), 64'(B_FRAME));

    // ---- small instance: asynchronous reset mid-frame ----
    reset_b_n = 1'b0;
    #1;
    check("b_reset_restart", mk(bx, by, bhs, bvs, bblank, bls, bfs, bfc), mk(10'd0, 10'd0, 1, 1, 0, 0, 0, 8'd0));
    tick();
    reset_b_n = 1'b1;
    tick();
    run(52);
    check("b_at_7_3", {bx, by, bblank}, {10'd7, 10'd3, 1'b1});
    #2;
    reset_b_n = 1'b0;
    #1;
    check("b_async_reset", mk(bx, by, bhs, bvs, bblank, bls, bfs, bfc), mk(10'd0, 10'd0, 1, 1, 0, 0, 0, 8'd0));
    tick();
    reset_b_n = 1'b1;
    tick();
    check("b_after_reset_edge1", mk(bx, by, bhs, bvs, bblank, bls, bfs, bfc),
          mk(10'd0, 10'd0, 1, 1, 1, 1, 1, FC_EN ? 8'd1 : 8'd0));
    tick();
    check("b_after_reset_edge2", {bx, by, bfs, bls}, {10'd1, 10'd0, 1'b0, 1'b0});

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan that sprite and palette drawers consume: DrawX/DrawY pixel coordinates, active-high visible-area strobe `blank`, active-low hs/vs syncs, plus frame and line start pulses.
- Sits between the pixel clock source and every per-pixel drawer.
- Drawers sample DrawX/DrawY/blank on the same vga_clk.
- Default timing is 640x480 @ 60 Hz with a 25 MHz vga_clk.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
vga_clk  input  1  pixel clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
pix_en  input  1  advance enable; 0 freezes all state and outputs
DrawX  output  10  current column, 0..H_TOTAL-1
DrawY  output  10  current row, 0..V_TOTAL-1
hs  output  1  horizontal sync, active low
vs  output  1  vertical sync, active low
blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE)
line_start  output  1  one-cycle pulse when DrawX==0
frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
frame_cnt  output  8  frame counter (optional feature)

Behaviour:
- Totals: H_TOTAL = sum of H_* (default 800); V_TOTAL = sum of V_* (default 525). Both must be ≤1024; frame = 420000 enabled clocks.
- Reset (reset_n low, async):
  - DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0, frame_cnt=0.
  - Internal run flag cleared.
- First enabled edge after release:
  - Sets run=1.
  - Counters hold at (0,0); outputs take their (0,0) values: blank=1, line_start=1, frame_start=1.
  - Pixel (0,0) of the first frame is therefore emitted, not skipped.
- Each later enabled edge:
  - DrawX increments.
  - At DrawX==H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawY==V_TOTAL-1 with DrawX wrapping, DrawY also wraps to 0.
- Alignment: hs, vs, blank, line_start and frame_start are registered from next-state counter values, so each is valid in the same cycle as the DrawX/DrawY it describes. Zero latency relative to the coordinates; glitch-free.
- hs=0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
- vs=0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491). vs changes only at DrawX==0.
- pix_en=0: every register holds, including pulses. A pulse asserted when pix_en drops stays high until the next enabled edge.
- Async reset mid-frame: immediate return to reset values; the next frame starts per the first-edge rule.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 (mod 256) on each enabled edge where frame_start becomes 1, including the first frame. First frame after reset therefore reads frame_cnt=1.
- Undefined: frame_cnt tied to 0 and no counter logic is synthesised. The port stays present so instantiations are identical.

Test Plan:
- Reset release, pix_en=1: edge 1 → DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1; edge 2 → DrawX=1, pulses 0.
- Run one line: blank falls when DrawX=640; hs=0 exactly for DrawX 656..751 (96 clocks); DrawX 799→0 with DrawY 0→1 and line_start=1.
- Run full frame: vs=0 exactly for DrawY 490..491 (1600 clocks); DrawY 524→0 at DrawX wrap; frame_start period = 420000 clocks.
- pix_en held 0 for 50 cycles at DrawX=655: all outputs frozen, hs stays 1; re-enable → DrawX=656, hs=0.
- Assert reset_n=0 at DrawX=300, DrawY=200: outputs go to reset values without waiting for a clock edge; after release, first edge gives frame_start=1 at (0,0).
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt reads 1 in frame 1, 3 after three frames, and wraps 255→0 at frame 256. Without the macro: frame_cnt=0 throughout.
